// File: rtl/sparrow_pkg.sv
// Shared register-file defaults and architectural register types.
package sparrow_pkg;

    localparam int unsigned REGFILE_DATA_W   = 32;
    localparam int unsigned REGFILE_NUM_REGS = 32;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] reg_data_t;

endpackage

// File: rtl/sparrow_regfile_wrsel.sv
// Reduces all write ports to a hit flag and winning data for one register index;
// the highest-index matching port wins.
module sparrow_regfile_wrsel
    import sparrow_pkg::*;
#(
    parameter int unsigned NUM_WR = 2,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = REGFILE_DATA_W
) (
    input  logic [ADDR_W-1:0]              i_idx,
    input  logic [NUM_WR-1:0]              i_wr_en,
    input  logic [NUM_WR-1:0][ADDR_W-1:0]  i_wr_addr,
    input  logic [NUM_WR-1:0][DATA_W-1:0]  i_wr_data,
    output logic                           o_hit_c,
    output logic [DATA_W-1:0]              o_data_c
);

    // Ascending scan so later (higher-index) ports override earlier ones.
    always_comb begin
        o_hit_c  = 1'b0;
        o_data_c = '0;
        for (int unsigned w = 0; w < NUM_WR; w++) begin
            if (i_wr_en[w] && (i_wr_addr[w] == i_idx)) begin
                o_hit_c  = 1'b1;
                o_data_c = i_wr_data[w];
            end
        end
    end

endmodule

// File: rtl/sparrow_regfile_sb.sv
// Multi-port integer register file with per-register busy scoreboard,
// prioritised write merge and optional write-to-read bypass.
module sparrow_regfile_sb
    import sparrow_pkg::*;
#(
    parameter int unsigned DATA_W   = REGFILE_DATA_W,
    parameter int unsigned NUM_REGS = REGFILE_NUM_REGS,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned NUM_WR   = 2,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1,
    localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic                           i_clk,
    input  logic                           i_reset_n,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]  i_rd_addr,
    output logic [NUM_RD-1:0][DATA_W-1:0]  o_rd_data,
    output logic [NUM_RD-1:0]              o_rd_busy,
    input  logic [NUM_WR-1:0]              i_wr_en,
    input  logic [NUM_WR-1:0][ADDR_W-1:0]  i_wr_addr,
    input  logic [NUM_WR-1:0][DATA_W-1:0]  i_wr_data,
    input  logic                           i_alloc_en,
    input  logic [ADDR_W-1:0]              i_alloc_addr,
    input  logic                           i_flush,
    output logic                           o_any_busy
);

    localparam bit HAS_ZERO   = (ZERO_REG != 0);
    localparam bit HAS_BYPASS = (BYPASS != 0);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]             busy_q, busy_d;
    logic [NUM_REGS-1:0]             wr_hit;
    logic [NUM_REGS-1:0][DATA_W-1:0] wr_sel_data;
    logic [NUM_RD-1:0]               byp_hit;
    logic [NUM_RD-1:0][DATA_W-1:0]   byp_data;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_wr_merge
        sparrow_regfile_wrsel #(
            .NUM_WR (NUM_WR),
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W)
        ) u_wrsel (
            .i_idx     (ADDR_W'(r)),
            .i_wr_en   (i_wr_en),
            .i_wr_addr (i_wr_addr),
            .i_wr_data (i_wr_data),
            .o_hit_c   (wr_hit[r]),
            .o_data_c  (wr_sel_data[r])
        );
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_byp
        if (HAS_BYPASS) begin : g_on
            sparrow_regfile_wrsel #(
                .NUM_WR (NUM_WR),
                .ADDR_W (ADDR_W),
                .DATA_W (DATA_W)
            ) u_wrsel (
                .i_idx     (i_rd_addr[p]),
                .i_wr_en   (i_wr_en),
                .i_wr_addr (i_wr_addr),
                .i_wr_data (i_wr_data),
                .o_hit_c   (byp_hit[p]),
                .o_data_c  (byp_data[p])
            );
        end else begin : g_off
            assign byp_hit[p]  = 1'b0;
            assign byp_data[p] = '0;
        end
    end

    // Busy priority: flush, then alloc, then writeback clear.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (HAS_ZERO && (r == 0)) begin
                regs_d[r] = '0;
                busy_d[r] = 1'b0;
            end else begin
                if (wr_hit[r]) begin
                    regs_d[r] = wr_sel_data[r];
                end
                if (i_flush) begin
                    busy_d[r] = 1'b0;
                end else if (i_alloc_en && (i_alloc_addr == ADDR_W'(r))) begin
                    busy_d[r] = 1'b1;
                end else if (wr_hit[r]) begin
                    busy_d[r] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Bypass is suppressed during reset so reads show the cleared state at once.
    always_comb begin
        o_rd_data = '0;
        o_rd_busy = '0;
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            o_rd_data[p] = regs_q[i_rd_addr[p]];
            o_rd_busy[p] = busy_q[i_rd_addr[p]];
            if (byp_hit[p] && i_reset_n) begin
                o_rd_data[p] = byp_data[p];
                o_rd_busy[p] = (i_alloc_en && (i_alloc_addr == i_rd_addr[p]))
                             ? busy_q[i_rd_addr[p]] : 1'b0;
            end
            if (HAS_ZERO && (i_rd_addr[p] == '0)) begin
                o_rd_data[p] = '0;
                o_rd_busy[p] = 1'b0;
            end
        end
    end

    assign o_any_busy = |busy_q;

endmodule

// File: tb/tb_sparrow_regfile_sb.sv
// Bench for sparrow_regfile_sb: a bypass and a non-bypass instance share stimulus.
module tb_sparrow_regfile_sb;

    logic              clk;
    logic              rst_n;
    logic [1:0][4:0]   rd_addr;
    logic [1:0][31:0]  rd_data_b, rd_data_n;
    logic [1:0]        rd_busy_b, rd_busy_n;
    logic              any_b, any_n;
    logic [1:0]        wr_en;
    logic [1:0][4:0]   wr_addr;
    logic [1:0][31:0]  wr_data;
    logic              alloc_en;
    logic [4:0]        alloc_addr;
    logic              flush;

    int total = 0;
    int bad   = 0;

    sparrow_regfile_sb #(.BYPASS(1)) u_dut_b (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_rd_addr(rd_addr), .o_rd_data(rd_data_b), .o_rd_busy(rd_busy_b),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_alloc_en(alloc_en), .i_alloc_addr(alloc_addr), .i_flush(flush),
        .o_any_busy(any_b)
    );

    sparrow_regfile_sb #(.BYPASS(0)) u_dut_n (
        .i_clk(clk), .i_reset_n(rst_n),
        .i_rd_addr(rd_addr), .o_rd_data(rd_data_n), .o_rd_busy(rd_busy_n),
        .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
        .i_alloc_en(alloc_en), .i_alloc_addr(alloc_addr), .i_flush(flush),
        .o_any_busy(any_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        ae;
        logic [4:0]  aa;
        logic        fl;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] ed0;   // bypass instance, port 0
        logic        eb0;
        logic [31:0] end0;  // non-bypass instance, port 0
        logic        enb0;
        logic [31:0] ed1;   // bypass instance, port 1
        logic        eany;
    } vec_t;

    typedef struct {
        int          idx;
        logic [31:0] ed0;
        logic        eb0;
        logic [31:0] end0;
        logic        enb0;
        logic [31:0] ed1;
        logic        eany;
    } exp_t;

    localparam int NVEC = 18;
    localparam logic [31:0] Z   = 32'h0000_0000;
    localparam logic [31:0] P1  = 32'h1111_1111;
    localparam logic [31:0] P2  = 32'h2222_2222;
    localparam logic [31:0] A5  = 32'hA5A5_A5A5;
    localparam logic [31:0] X42 = 32'h0000_0042;
    localparam logic [31:0] FF  = 32'hFFFF_FFFF;
    localparam logic [31:0] DB  = 32'hDEAD_BEEF;

    vec_t vecs [NVEC];
    exp_t sbq [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wr_en      = 2'b00;
        wr_addr    = '0;
        wr_data    = '0;
        alloc_en   = 1'b0;
        alloc_addr = 5'd0;
        flush      = 1'b0;
    endtask

    initial begin
        exp_t e;

        //             we     wa0   wd0  wa1   wd1  ae    aa    fl    ra0   ra1    ed0  eb0   end0 enb0  ed1  eany
        vecs[0]  = '{2'b11, 5'd5, P1,  5'd5, P2,  1'b0, 5'd0, 1'b0, 5'd5, 5'd5,  P2,  1'b0, Z,   1'b0, P2,  1'b0};
        vecs[1]  = '{2'b00, 5'd0, Z,   5'd0, Z,   1'b0, 5'd0, 1'b0, 5'd5, 5'd0,  P2,  1'b0, P2,  1'b0, Z,   1'b0};
        vecs[2]  = '{2'b10, 5'd0, Z,   5'd0, FF,  1'b1, 5'd0, 1'b0, 5'd0, 5'd0,  Z,   1'b0, Z,   1'b0, Z,   1'b0};
        vecs[3]  = '{2'b00, 5'd0, Z,   5'd0, Z,   1'b0, 5'd0, 1'b0, 5'd0, 5'd5,  Z,   1'b0, Z,   1'b0, P2,  1'b0};
        vecs[4]  = '{2'b00, 5'd0, Z,   5'd0, Z,   1'b1, 5'd7, 1'b0, 5'd7, 5'd5,  Z,   1'b0, Z,   1'b0, P2,  1'b0};
        vecs[5]  = '{2'b00, 5'd0, Z,   5'd0, Z,   1'b0, 5'd0, 1'b0, 5'd7, 5'd7,  Z,   1'b1, Z,   1'b1, Z,   1'b1};
        vecs[6]  = '{2'b00, 5'd0, Z,   5'd0, Z,   1'b0, 5'd0, 1'b0, 5'd7, 5'd7,  Z,   1'b1, Z,   1'b1, Z,   1'b1};
        vecs[7]  = '{2'b01, 5'd7, A5,  5'd0, Z,   1'b0, 5'd0, 1'b0, 5'd7, 5'd7,  A5,  1'b0, Z,   1'b1, A5,  1'b1};
        vecs[8]  = '{2'b00, 5'd0, Z,   5'd0, Z,   1'b0, 5'd0, 1'b0, 5'd7, 5'd7,  A5,  1'b0, A5,  1'b0, A5,  1'b0};
        vecs[9]  = '{2'b10, 5'd0, Z,   5'd9, X42, 1'b1, 5'd9, 1'b0, 5'd9, 5'd9,  X42, 1'b0, Z,   1'b0, X42, 1'b0};
        vecs[10] = '{2'b00, 5'd0, Z,   5'd0, Z,   1'b0, 5'd0, 1'b0, 5'd9, 5'd7,  X42, 1'b1, X42, 1'b1, A5,  1'b1};
        vecs[11] = '{2'b00, 5'd0, Z,   5'd0, Z,   1'b1, 5'd3, 1'b0, 5'd3, 5'd9,  Z,   1'b0, Z,   1'b0, X42, 1'b1};
        vecs[12] = '{2'b00, 5'd0, Z,   5'd0, Z,   1'b1, 5'd4, 1'b0, 5'd3, 5'd9,  Z,   1'b1, Z,   1'b1, X42, 1'b1};
        vecs[13] = '{2'b00, 5'd0, Z,   5'd0, Z,   1'b1, 5'd6, 1'b0, 5'd4, 5'd9,  Z,   1'b1, Z,   1'b1, X42, 1'b1};
        vecs[14] = '{2'b00, 5'd0, Z,   5'd0, Z,   1'b1, 5'd8, 1'b1, 5'd6, 5'd8,  Z,   1'b1, Z,   1'b1, Z,   1'b1};
        vecs[15] = '{2'b00, 5'd0, Z,   5'd0, Z,   1'b0, 5'd0, 1'b0, 5'd8, 5'd9,  Z,   1'b0, Z,   1'b0, X42, 1'b0};
        vecs[16] = '{2'b00, 5'd0, Z,   5'd0, Z,   1'b0, 5'd0, 1'b0, 5'd9, 5'd7,  X42, 1'b0, X42, 1'b0, A5,  1'b0};
        vecs[17] = '{2'b00, 5'd0, Z,   5'd0, Z,   1'b0, 5'd0, 1'b0, 5'd6, 5'd3,  Z,   1'b0, Z,   1'b0, Z,   1'b0};

        rst_n   = 1'b0;
        rd_addr = '0;
        idle_inputs();

        #2;
        chk("init_d0", rd_data_b[0], Z);
        chk("init_b0", 32'(rd_busy_b[0]), Z);
        chk("init_any", 32'(any_b), Z);
        chk("init_any_n", 32'(any_n), Z);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(posedge clk);
            #1;
            wr_en      = vecs[i].we;
            wr_addr[0] = vecs[i].wa0;
            wr_data[0] = vecs[i].wd0;
            wr_addr[1] = vecs[i].wa1;
            wr_data[1] = vecs[i].wd1;
            alloc_en   = vecs[i].ae;
            alloc_addr = vecs[i].aa;
            flush      = vecs[i].fl;
            rd_addr[0] = vecs[i].ra0;
            rd_addr[1] = vecs[i].ra1;
            sbq.push_back('{i, vecs[i].ed0, vecs[i].eb0, vecs[i].end0,
                            vecs[i].enb0, vecs[i].ed1, vecs[i].eany});
            @(negedge clk);
            if (sbq.size() == 0) begin
                chk("sb_underflow", 32'd0, 32'd1);
            end else begin
                e = sbq.pop_front();
                chk($sformatf("v%0d_d0", e.idx),   rd_data_b[0], e.ed0);
                chk($sformatf("v%0d_b0", e.idx),   32'(rd_busy_b[0]), 32'(e.eb0));
                chk($sformatf("v%0d_nd0", e.idx),  rd_data_n[0], e.end0);
                chk($sformatf("v%0d_nb0", e.idx),  32'(rd_busy_n[0]), 32'(e.enb0));
                chk($sformatf("v%0d_d1", e.idx),   rd_data_b[1], e.ed1);
                chk($sformatf("v%0d_any", e.idx),  32'(any_b), 32'(e.eany));
                chk($sformatf("v%0d_anyn", e.idx), 32'(any_n), 32'(e.eany));
            end
        end

        // Preload every register with DEADBEEF, two writes per cycle, then one alloc.
        for (int r = 0; r < 32; r += 2) begin
            @(posedge clk);
            #1;
            idle_inputs();
            wr_en      = 2'b11;
            wr_addr[0] = 5'(r);
            wr_addr[1] = 5'(r + 1);
            wr_data[0] = DB;
            wr_data[1] = DB;
        end
        @(posedge clk);
        #1;
        idle_inputs();
        alloc_en   = 1'b1;
        alloc_addr = 5'd12;
        @(posedge clk);
        #1;
        idle_inputs();
        rd_addr[0] = 5'd31;
        rd_addr[1] = 5'd0;
        #1;
        chk("pre_r31", rd_data_b[0], DB);
        chk("pre_r31_n", rd_data_n[0], DB);
        chk("pre_r0", rd_data_b[1], Z);
        chk("pre_any", 32'(any_b), 32'd1);

        // Assert reset mid-cycle with a write and alloc pending to r10.
        @(posedge clk);
        #2;
        wr_en      = 2'b01;
        wr_addr[0] = 5'd10;
        wr_data[0] = 32'h1234_5678;
        alloc_en   = 1'b1;
        alloc_addr = 5'd10;
        rst_n      = 1'b0;
        #1;
        chk("rst_any", 32'(any_b), Z);
        chk("rst_any_n", 32'(any_n), Z);
        for (int a = 0; a < 32; a++) begin
            rd_addr[0] = 5'(a);
            rd_addr[1] = 5'(31 - a);
            #1;
            chk($sformatf("rst_d0_r%0d", a), rd_data_b[0], Z);
            chk($sformatf("rst_b0_r%0d", a), 32'(rd_busy_b[0]), Z);
            chk($sformatf("rst_nd0_r%0d", a), rd_data_n[0], Z);
            chk($sformatf("rst_nb0_r%0d", a), 32'(rd_busy_n[0]), Z);
            chk($sformatf("rst_d1_r%0d", 31 - a), rd_data_b[1], Z);
        end
        @(negedge clk);
        idle_inputs();
        rst_n      = 1'b1;
        rd_addr[0] = 5'd10;
        rd_addr[1] = 5'd12;
        #1;
        chk("post_rst_r10", rd_data_b[0], Z);
        chk("post_rst_b10", 32'(rd_busy_b[0]), Z);
        chk("post_rst_nr10", rd_data_n[0], Z);
        chk("post_rst_b12", 32'(rd_busy_b[1]), Z);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
